// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: value handshake into the display controller.
// in_valid/in_data from the producer, in_ready back from the controller.
interface seg_scan_ctrl_if;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: binary 0..999 -> BCD (shift-add-3), latched, scanned onto
// a 3-digit 7-seg bus. Ports: clk, rst (sync high), bus (slave handshake:
// in_valid, in_data[11:0], in_ready), busy, seg[7:0] (a..dp), dig_sel[2:0]
// (001 units, 010 tens, 100 hundreds). Option: BLANK_LEADING_ZERO_EN.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus,
    output logic            busy,
    output logic [7:0]      seg,
    output logic [2:0]      dig_sel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_LATCH
    } state_t;

    localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

    state_t      state;
    logic [11:0] shift;
    logic [11:0] bcd;
    logic [3:0]  cnt;
    logic        ovf;

    logic [3:0]  disp_u;
    logic [3:0]  disp_t;
    logic [3:0]  disp_h;
    logic        disp_dash;

    logic [19:0] div;
    logic [1:0]  idx;

    logic [3:0]  cur_dig;
    logic        blank;
    logic [7:0]  cur_seg;
    logic [2:0]  cur_sel;
    logic [11:0] bcd_adj;

    // Each BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] dec7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hfc;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hda;
            4'd3:    s = 8'hf2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hb6;
            4'd6:    s = 8'hbe;
            4'd7:    s = 8'he0;
            4'd8:    s = 8'hfe;
            4'd9:    s = 8'hf6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign bcd_adj = add3(bcd);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            shift        <= '0;
            bcd          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            disp_u       <= '0;
            disp_t       <= '0;
            disp_h       <= '0;
            disp_dash    <= 1'b0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        if (bus.in_data > 12'd999) begin
                            ovf   <= 1'b1;
                            state <= S_LATCH;
                        end else begin
                            shift <= bus.in_data;
                            bcd   <= '0;
                            cnt   <= '0;
                            state <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    bcd   <= {bcd_adj[10:0], shift[11]};
                    shift <= {shift[10:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd11)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    if (ovf) begin
                        disp_u <= '0;
                        disp_t <= '0;
                        disp_h <= '0;
                    end else begin
                        disp_u <= bcd[3:0];
                        disp_t <= bcd[7:4];
                        disp_h <= bcd[11:8];
                    end
                    disp_dash    <= ovf;
                    ovf          <= 1'b0;
                    bus.in_ready <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_dig = disp_u;
        cur_sel = 3'b001;
        unique case (idx)
            2'd1: begin
                cur_dig = disp_t;
                cur_sel = 3'b010;
            end
            2'd2: begin
                cur_dig = disp_h;
                cur_sel = 3'b100;
            end
            default: begin
                cur_dig = disp_u;
                cur_sel = 3'b001;
            end
        endcase
    end

`ifdef BLANK_LEADING_ZERO_EN
    assign blank = ((idx == 2'd2) && (disp_h == 4'd0)) ||
                   ((idx == 2'd1) && (disp_h == 4'd0) && (disp_t == 4'd0));
`else
    assign blank = 1'b0;
`endif

    // Dashes win over blanking so overflow is always visible.
    assign cur_seg = disp_dash ? 8'h02 :
                     blank     ? 8'h00 : dec7(cur_dig);

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            idx     <= '0;
            seg     <= '0;
            dig_sel <= '0;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                div <= div + 20'd1;
            end
            seg     <= cur_seg;
            dig_sel <= cur_sel;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed vectors for seg_scan_ctrl (SCAN_DIV=4).
// Expected digit triplets go into a queue; a monitor checks a full frame.
module tb_seg_scan_ctrl;

    localparam int SD = 4;

`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [7:0] BZ = 8'h00;
`else
    localparam logic [7:0] BZ = 8'hfc;
`endif

    typedef struct packed {
        logic [7:0] u;
        logic [7:0] t;
        logic [7:0] h;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] seg;
    logic [2:0] dig_sel;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_active = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    function automatic exp_t mk(input logic [7:0] u, input logic [7:0] t,
                                input logic [7:0] h);
        exp_t e;
        e.u = u;
        e.t = t;
        e.h = h;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [11:0] v, input exp_t e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 12'($urandom);
    endtask

    task automatic measure_busy(input int want);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (n == 0)
                check("ready_low_while_busy", 32'(bus.in_ready), 32'd0);
            n++;
        end
        check("busy_len", 32'(n), 32'(want));
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !mon_active) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: timeout, queue=%0d", q.size());
        end
    endtask

    // Monitor: each time busy falls, one frame of the display is checked.
    initial begin : monitor
        bit   pb;
        exp_t e;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (pb && !busy) begin
                mon_active = 1'b1;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: no entry queued");
                end else begin
                    e = q.pop_front();
                    @(posedge clk);
                    for (int i = 0; i < 3 * SD; i++) begin
                        @(negedge clk);
                        case (dig_sel)
                            3'b001: check("units", 32'(seg), 32'(e.u));
                            3'b010: check("tens", 32'(seg), 32'(e.t));
                            3'b100: check("hundreds", 32'(seg), 32'(e.h));
                            default: begin
                                tests++;
                                fails++;
                                $display("FAIL dig_sel_onehot: got %b", dig_sel);
                            end
                        endcase
                    end
                end
                mon_active = 1'b0;
            end
            pb = busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0] want_sel;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_dig_sel", 32'(dig_sel), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // Free-running scan after reset: 4 cycles per digit.
        for (int i = 0; i < 3 * SD; i++) begin
            @(negedge clk);
            want_sel = 3'b001 << (i / SD);
            check("scan_sel", 32'(dig_sel), 32'(want_sel));
            check("scan_seg", 32'(seg), (i < SD) ? 32'hfc : 32'(BZ));
        end
        check("idle_ready", 32'(bus.in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        send(12'd999, mk(8'hf6, 8'hf6, 8'hf6));
        measure_busy(13);
        wait_idle();

        // 111 offered during CONV must be ignored.
        send(12'd305, mk(8'hb6, 8'hfc, 8'hf2));
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("conv_ready_low", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_idle();

        send(12'd7, mk(8'he0, BZ, BZ));
        wait_idle();

        send(12'd40, mk(8'hfc, 8'h66, BZ));
        wait_idle();

        send(12'd1000, mk(8'h02, 8'h02, 8'h02));
        measure_busy(1);
        wait_idle();

        send(12'd0, mk(8'hfc, BZ, BZ));
        wait_idle();

        send(12'd4095, mk(8'h02, 8'h02, 8'h02));
        measure_busy(1);
        wait_idle();

        // Reset on the 6th CONV cycle: 512 must never appear.
        send(12'd512, mk(8'hfc, BZ, BZ));
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_seg", 32'(seg), 32'h00);
        check("abort_dig_sel", 32'(dig_sel), 32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Sequencing controller for the calculator's three-digit seven-segment display. It accepts a binary result of 0–999 through a valid/ready handshake and converts it to BCD with a sequential shift-add-3 engine. It latches the digits into a display register and time-multiplexes them onto one shared segment bus with a one-hot digit select. It sits between the calculator datapath's result register and the board display pins, and replaces purely combinational per-digit decoding.

## Interface
- SCAN_DIV, 50000, clock cycles each digit stays selected; legal range 2..2^20.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is offered.
- in_data  in  12  unsigned binary value; 0–999 legal, 1000–4095 is overflow.
- in_ready  out  1  block can accept a value; high only in IDLE.
- busy  out  1  conversion or latch in progress; high in CONV and LATCH.
- seg  out  8  segment code, active-high, bit7..bit0 = a,b,c,d,e,f,g,dp.
- dig_sel  out  3  one-hot digit enable, active-high: 001 = units, 010 = tens, 100 = hundreds.

## Operation
- FSM states: IDLE, CONV, LATCH.
  - IDLE: in_ready=1. A transfer occurs when in_valid && in_ready.
  - On a transfer with in_data ≤ 999: capture in_data into a shift register, clear the 12-bit BCD accumulator, clear the iteration counter, go to CONV.
  - On a transfer with in_data > 999: set the overflow flag and go directly to LATCH.
- CONV runs exactly 12 iterations, one per clock, MSB first. Each iteration:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, shift} shifts left by 1.
  - After iteration 12, go to LATCH.
- LATCH: write the three digits to the display register (overflow → all three digits show "-", code 8'h02), clear the overflow flag, go to IDLE.
- Segment codes (a..dp):
  - 0=fc, 1=60, 2=da, 3=f2, 4=66, 5=b6, 6=be, 7=e0, 8=fe, 9=f6.
  - Blank = 00; dash = 02.
  - A digit code 10–15 never reaches the display register; the decoder default is 00.
- Scan engine runs free and is independent of the FSM:
  - A divider counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→0.
  - seg and dig_sel are registered from the display register and the index every cycle.
- A new display register value appears on seg the cycle after LATCH, even mid-digit. There is no wait for a scan boundary.
- in_valid while busy is ignored: there is no transfer and no queuing. in_data need not be held after the transfer.

## Timing
- Reset values:
  - Display register = 0,0,0.
  - State = IDLE, divider = 0, index = 0, overflow = 0.
  - seg = 8'h00, dig_sel = 3'b000, in_ready = 1, busy = 0.
- The first clock after rst deasserts drives dig_sel=001 and seg=fc.
- Latency, legal value: transfer at edge T0; CONV covers edges T1..T12; LATCH at edge T13 writes the display register; seg reflects it after T14; in_ready is high again after T13. Back-to-back transfers happen every 14 cycles.
- Latency, overflow: transfer at T0, LATCH at T1, in_ready high after T1.
- Each digit is selected for exactly SCAN_DIV cycles. A full frame is 3·SCAN_DIV cycles.
- rst mid-CONV or mid-LATCH aborts the conversion:
  - The partial result is discarded.
  - The display register is cleared to 0,0,0.
  - All reset values apply on the next cycle.

## Configuration
- BLANK_LEADING_ZERO_EN defined:
  - The hundreds digit shows 8'h00 when it is 0.
  - The tens digit shows 8'h00 when both hundreds and tens are 0.
  - The units digit is never blanked.
  - Overflow dashes are never blanked.
- BLANK_LEADING_ZERO_EN undefined: all three digits are always displayed. 7 shows as "007".

## Test plan
All scenarios use SCAN_DIV=4 unless stated.
- Reset, then observe 12 cycles → dig_sel cycles 001,010,100 for 4 cycles each; seg=fc throughout; in_ready=1, busy=0.
- Send in_data=999, in_valid pulsed for one cycle → busy high for 13 cycles, in_ready low during that time; then the units, tens and hundreds slots each show f6.
- Send 305, and assert in_valid again with 111 during CONV → 111 is ignored. Display: units b6, tens fc, hundreds f2 (with BLANK_LEADING_ZERO_EN: same, since the zero is not leading).
- Send 7 → without the macro: units e0, tens fc, hundreds fc. With BLANK_LEADING_ZERO_EN: units e0, tens 00, hundreds 00.
- Send 1000 → busy for 1 cycle; all three digits show 02. Then send 0 → all digits fc (macro off).
- Send 512, assert rst at the 6th CONV cycle → display 0,0,0; state IDLE; seg=00 and dig_sel=000 on the reset cycle; 512 is never displayed.
